layer_mac_sequencer: RTL
========================

// Module: layer_mac_sequencer
// PURPOSE
//   Time-multiplexed controller for one fully connected layer. Captures an input vector,
//   then walks every neuron through a single shared 32-bit MAC: it streams weights and the
//   bias from a sync-read coefficient RAM, applies the Q13 ReLU and returns one result per
//   neuron over a valid/ready stream. It replaces N_OUT parallel per-neuron node instances.
// PARAMETERS
//   N_IN   10  inputs per neuron (>=2)
//   N_OUT  8   neurons in the layer (>=1)
//   DW     32  data/coefficient width, two's complement
//   FRAC   13  fractional bits; result = acc[FRAC+15:FRAC]
//   WAW    8   coefficient address width, must satisfy 2^WAW >= N_OUT*(N_IN+1)
//   IDXW   3   neuron index width, must satisfy 2^IDXW >= N_OUT
//   RELU   1   1: negative acc -> 0; 0: output is acc[FRAC+15:FRAC] sign-extended to DW
// PORTS
//   clk        in   1          clock, rising edge
//   reset      in   1          asynchronous, active-low reset
//   in_valid   in   1          input vector valid
//   in_ready   out  1          high only in IDLE
//   in_data    in   DW*N_IN    flattened inputs, a[k] = in_data[k*DW +: DW]
//   w_rd       out  1          coefficient read strobe
//   w_addr     out  WAW        coefficient address
//   w_data     in   DW         coefficient, valid the cycle after w_rd (1-cycle latency)
//   out_valid  out  1          result valid, held until accepted
//   out_ready  in   1          downstream accept
//   out_data   out  DW         neuron result
//   out_idx    out  IDXW       neuron number of out_data
//   out_last   out  1          out_idx == N_OUT-1
//   busy       out  1          state != IDLE
// BEHAVIOUR
//   Reset (reset=0, async): state=IDLE; in_ready=1; w_rd=0; w_addr=0; out_valid=0;
//     out_data=0; out_idx=0; out_last=0; busy=0; acc, n, k and input regs cleared. An
//     in-flight frame is discarded; no partial output is ever emitted after reset.
//   RAM layout: neuron n occupies addr n*(N_IN+1)+k; k=0..N_IN-1 weights, k=N_IN bias.
//   FSM IDLE -> RUN -> LAST -> OUT -> (RUN | IDLE):
//     IDLE: on in_valid&in_ready edge latch all a[k], n=0, k=0, acc=0 -> RUN.
//       in_valid while not in IDLE is ignored (in_ready=0); in_data is sampled only here.
//     RUN: N_IN+1 cycles; cycle c drives w_rd=1, w_addr=n*(N_IN+1)+c. Weight issued in
//       cycle c is multiplied by a[c] and added to acc at the end of cycle c+1 (delayed index).
//     LAST: 1 cycle, w_rd=0; bias arriving this cycle is added; result computed from
//       acc+bias and registered into out_data, out_idx=n, out_last=(n==N_OUT-1) -> OUT.
//     OUT: out_valid=1, out_data/out_idx/out_last stable until out_ready. On handshake:
//       n==N_OUT-1 -> IDLE (out_valid=0); else n++, k=0, acc=0 -> RUN same edge.
//   Latency: first out_valid N_IN+2 cycles after input accept edge; with out_ready=1
//     neuron period N_IN+3 cycles, frame N_OUT*(N_IN+3) cycles + return to IDLE.
//   Arithmetic: a*w truncated to DW bits (mod 2^32); acc wraps mod 2^32, no saturation.
//     RELU=1: acc[DW-1]=1 -> 0, else zero-extended acc[FRAC+15:FRAC] (upper bits dropped).
//   w_rd is never asserted outside RUN; w_addr holds last value when w_rd=0.
// TESTING (N_IN=10, N_OUT=2, RELU=1)
//   1 All a=8192, n0 weights=819, bias 633 -> out_idx=0, out_data=8190, out_valid at
//     accept+12 cycles, out_last=0.
//   2 n1 weights=-8192, bias 0, a=8192 -> out_idx=1, out_data=0, out_last=1, then in_ready=1.
//   3 Addresses: n0 issues w_addr 0..10, n1 issues 11..21, each once, w_rd=1 only in RUN.
//   4 out_ready=0 for 5 cycles in OUT -> out_valid/out_data/out_idx stable, w_rd=0, no
//     progress; accept on cycle 6 -> n1 RUN starts next cycle.
//   5 in_valid pulsed with new data during RUN -> ignored; results match first vector.
//   6 reset=0 mid-RUN of n1 -> all outputs at reset values immediately; after release,
//     new frame with test-1 data yields out_data=8190 for n0 with correct timing.

Source files
------------

// File: rtl/layer_mac_sequencer_if.sv
// Bus bundle for the layer MAC sequencer: input vector stream, coefficient RAM port,
// and result stream. The master side is the environment and the slave side is the sequencer.
interface layer_mac_sequencer_if #(
    parameter int N_IN = 10,
    parameter int DW   = 32,
    parameter int WAW  = 8,
    parameter int IDXW = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [DW*N_IN-1:0] in_data;
    logic               w_rd;
    logic [WAW-1:0]     w_addr;
    logic [DW-1:0]      w_data;
    logic               out_valid;
    logic               out_ready;
    logic [DW-1:0]      out_data;
    logic [IDXW-1:0]    out_idx;
    logic               out_last;
    logic               busy;

    modport master (
        output in_valid, in_data, w_data, out_ready,
        input  in_ready, w_rd, w_addr, out_valid, out_data, out_idx, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, w_data, out_ready,
        output in_ready, w_rd, w_addr, out_valid, out_data, out_idx, out_last, busy
    );
endinterface

// File: rtl/layer_mac_sequencer.sv
// One fully connected layer evaluated neuron by neuron on a single shared MAC,
// with weights and bias streamed from a coefficient RAM that has a one-cycle read latency.
module layer_mac_sequencer #(
    parameter int N_IN  = 10,
    parameter int N_OUT = 8,
    parameter int DW    = 32,
    parameter int FRAC  = 13,
    parameter int WAW   = 8,
    parameter int IDXW  = 3,
    parameter int RELU  = 1
) (
    input logic                 clk,
    input logic                 reset,
    layer_mac_sequencer_if.slave bus
);
    localparam int              KW     = $clog2(N_IN + 1);
    localparam logic [KW-1:0]   K_LAST = KW'(N_IN);
    localparam logic [IDXW-1:0] N_LAST = IDXW'(N_OUT - 1);
    localparam int              SHL    = DW - FRAC - 16;
    localparam logic [DW-1:0]   LOW16  = {{(DW-16){1'b0}}, {16{1'b1}}};

    typedef enum logic [1:0] {IDLE, RUN, LAST, OUT} state_t;
    state_t state, state_next;

    logic [DW-1:0]   a_reg [N_IN];
    logic [IDXW-1:0] n;
    logic [KW-1:0]   k;
    logic [DW-1:0]   acc;
    logic [WAW-1:0]  addr;
    logic [DW-1:0]   out_data_r;
    logic [IDXW-1:0] out_idx_r;
    logic            out_last_r;
    logic [DW-1:0]   prod, sum, field, result;
    logic            in_ready, w_rd, out_valid, busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.in_valid) state_next = RUN;
            RUN:     if (k == K_LAST) state_next = LAST;
            LAST:    state_next = OUT;
            OUT:     if (bus.out_ready) state_next = (n == N_LAST) ? IDLE : RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        w_rd      = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE:    begin in_ready = 1'b1; busy = 1'b0; end
            RUN:     w_rd = 1'b1;
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    // The weight on w_data during RUN cycle k was issued in cycle k-1, hence the delayed tap index.
    // The shift pair extracts acc[FRAC+15:FRAC] sign-extended; RELU masks it down to 16 bits.
    always_comb begin
        prod  = a_reg[k - KW'(1)] * bus.w_data;
        sum   = acc + bus.w_data;
        field = $signed(sum << SHL) >>> (DW - 16);
        if (RELU != 0) result = sum[DW-1] ? '0 : (field & LOW16);
        else           result = field;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_IN; i++) a_reg[i] <= '0;
            n          <= '0;
            k          <= '0;
            acc        <= '0;
            addr       <= '0;
            out_data_r <= '0;
            out_idx_r  <= '0;
            out_last_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    for (int i = 0; i < N_IN; i++) a_reg[i] <= bus.in_data[i*DW +: DW];
                    n    <= '0;
                    k    <= '0;
                    acc  <= '0;
                    addr <= '0;
                end
                RUN: begin
                    if (k != '0) acc <= acc + prod;
                    if (k != K_LAST) begin
                        k    <= k + KW'(1);
                        addr <= addr + WAW'(1);
                    end
                end
                LAST: begin
                    out_data_r <= result;
                    out_idx_r  <= n;
                    out_last_r <= (n == N_LAST);
                end
                // Coefficients are laid out contiguously, so the next neuron starts right after this bias.
                OUT: if (bus.out_ready && n != N_LAST) begin
                    n    <= n + IDXW'(1);
                    k    <= '0;
                    acc  <= '0;
                    addr <= addr + WAW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.w_rd      = w_rd;
    assign bus.w_addr    = addr;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = busy;
endmodule
